// File: rtl/common_types_pkg.sv
// Shared front-end types and defaults used by the fem_monitor slice.
package common_types_pkg;

  typedef struct packed {
    logic sign;
    logic mag;
  } fem_sample_t;

  localparam int FEM_HB_HALF_DEFAULT = 960000;

endpackage

// File: rtl/fem_mon_channel.sv
// One channel of windowed sign/magnitude statistics with threshold flags.
// Sign accumulation and bias flag exist only when FEM_MON_SIGN_BIAS_EN is defined.
module fem_mon_channel
  import common_types_pkg::*;
#(
  parameter int WINDOW   = 4096,
  parameter int MAG_LO   = WINDOW / 4,
  parameter int MAG_HI   = WINDOW / 2,
  parameter int BIAS_TOL = WINDOW / 8,
  parameter int CW       = $clog2(WINDOW + 1)
) (
  input  logic          CLK,
  input  logic          ck_rst,
  input  logic          sample_en_i,
  input  logic          close_i,
  input  logic          sign_i,
  input  logic          mag_i,
  output logic [CW-1:0] mag_count_o,
  output logic          mag_low_o,
  output logic          mag_high_o,
  output logic [CW-1:0] sign_count_o,
  output logic          sign_bias_o
);

  fem_sample_t   smp;
  logic [CW-1:0] acc_mag_q, acc_mag_d, mag_sum;
  logic [CW-1:0] mag_count_q, mag_count_d;
  logic          mag_low_q, mag_low_d, mag_high_q, mag_high_d;

  assign smp     = '{sign: sign_i, mag: mag_i};
  // The closing sample is folded in before latching, so the window is complete.
  assign mag_sum = acc_mag_q + CW'(smp.mag);

  always_comb begin
    acc_mag_d   = acc_mag_q;
    mag_count_d = mag_count_q;
    mag_low_d   = mag_low_q;
    mag_high_d  = mag_high_q;
    if (close_i) begin
      acc_mag_d   = '0;
      mag_count_d = mag_sum;
      mag_low_d   = mag_sum < CW'(MAG_LO);
      mag_high_d  = mag_sum > CW'(MAG_HI);
    end else if (sample_en_i) begin
      acc_mag_d = mag_sum;
    end
  end

  always_ff @(posedge CLK) begin
    if (!ck_rst) begin
      acc_mag_q   <= '0;
      mag_count_q <= '0;
      mag_low_q   <= 1'b0;
      mag_high_q  <= 1'b0;
    end else begin
      acc_mag_q   <= acc_mag_d;
      mag_count_q <= mag_count_d;
      mag_low_q   <= mag_low_d;
      mag_high_q  <= mag_high_d;
    end
  end

  assign mag_count_o = mag_count_q;
  assign mag_low_o   = mag_low_q;
  assign mag_high_o  = mag_high_q;

`ifdef FEM_MON_SIGN_BIAS_EN
  localparam logic [CW:0] HALF = (CW + 1)'(WINDOW / 2);
  localparam logic [CW:0] TOL  = (CW + 1)'(BIAS_TOL);

  logic [CW-1:0] acc_sign_q, acc_sign_d, sign_sum;
  logic [CW-1:0] sign_count_q, sign_count_d;
  logic          sign_bias_q, sign_bias_d;
  logic [CW:0]   sign_ext, bias_diff;

  assign sign_sum  = acc_sign_q + CW'(smp.sign);
  // One extra bit keeps the absolute difference unsigned and overflow-free.
  assign sign_ext  = {1'b0, sign_sum};
  assign bias_diff = (sign_ext >= HALF) ? (sign_ext - HALF) : (HALF - sign_ext);

  always_comb begin
    acc_sign_d   = acc_sign_q;
    sign_count_d = sign_count_q;
    sign_bias_d  = sign_bias_q;
    if (close_i) begin
      acc_sign_d   = '0;
      sign_count_d = sign_sum;
      sign_bias_d  = bias_diff > TOL;
    end else if (sample_en_i) begin
      acc_sign_d = sign_sum;
    end
  end

  always_ff @(posedge CLK) begin
    if (!ck_rst) begin
      acc_sign_q   <= '0;
      sign_count_q <= '0;
      sign_bias_q  <= 1'b0;
    end else begin
      acc_sign_q   <= acc_sign_d;
      sign_count_q <= sign_count_d;
      sign_bias_q  <= sign_bias_d;
    end
  end

  assign sign_count_o = sign_count_q;
  assign sign_bias_o  = sign_bias_q;
`else
  logic unused_sign;
  assign unused_sign  = smp.sign;
  assign sign_count_o = '0;
  assign sign_bias_o  = 1'b0;
`endif

endmodule

// File: rtl/fem_monitor.sv
// Front-end health monitor: sample-clock heartbeat plus per-channel window statistics.
// Optional sign statistics are enabled by defining FEM_MON_SIGN_BIAS_EN.
module fem_monitor
  import common_types_pkg::*;
#(
  parameter int N_CH     = 2,
  parameter int WINDOW   = 4096,
  parameter int HB_HALF  = FEM_HB_HALF_DEFAULT,
  parameter int MAG_LO   = WINDOW / 4,
  parameter int MAG_HI   = WINDOW / 2,
  parameter int BIAS_TOL = WINDOW / 8,
  parameter int CW       = $clog2(WINDOW + 1)
) (
  input  logic               CLK,
  input  logic               ck_rst,
  input  logic               en,
  input  logic [N_CH-1:0]    sign_i,
  input  logic [N_CH-1:0]    mag_i,
  output logic               heartbeat_o,
  output logic               stat_valid_o,
  output logic [N_CH*CW-1:0] mag_count_o,
  output logic [N_CH-1:0]    mag_low_o,
  output logic [N_CH-1:0]    mag_high_o,
  output logic [N_CH*CW-1:0] sign_count_o,
  output logic [N_CH-1:0]    sign_bias_o
);

  localparam int HW = (HB_HALF > 1) ? $clog2(HB_HALF) : 1;

  logic [HW-1:0] hb_q, hb_d;
  logic          heartbeat_q, heartbeat_d;
  logic [CW-1:0] wc_q, wc_d;
  logic          stat_valid_q;
  logic          hb_wrap, close;

  assign hb_wrap = (hb_q == HW'(HB_HALF - 1));
  assign close   = en && (wc_q == CW'(WINDOW - 1));

  always_comb begin
    hb_d        = hb_wrap ? '0 : hb_q + 1'b1;
    heartbeat_d = heartbeat_q ^ hb_wrap;
    wc_d        = wc_q;
    if (en) begin
      wc_d = close ? '0 : wc_q + 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (!ck_rst) begin
      hb_q         <= '0;
      heartbeat_q  <= 1'b0;
      wc_q         <= '0;
      stat_valid_q <= 1'b0;
    end else begin
      hb_q         <= hb_d;
      heartbeat_q  <= heartbeat_d;
      wc_q         <= wc_d;
      stat_valid_q <= close;
    end
  end

  assign heartbeat_o  = heartbeat_q;
  assign stat_valid_o = stat_valid_q;

  for (genvar gi = 0; gi < N_CH; gi++) begin : g_ch
    fem_mon_channel #(
      .WINDOW  (WINDOW),
      .MAG_LO  (MAG_LO),
      .MAG_HI  (MAG_HI),
      .BIAS_TOL(BIAS_TOL),
      .CW      (CW)
    ) u_ch (
      .CLK         (CLK),
      .ck_rst      (ck_rst),
      .sample_en_i (en),
      .close_i     (close),
      .sign_i      (sign_i[gi]),
      .mag_i       (mag_i[gi]),
      .mag_count_o (mag_count_o[gi*CW +: CW]),
      .mag_low_o   (mag_low_o[gi]),
      .mag_high_o  (mag_high_o[gi]),
      .sign_count_o(sign_count_o[gi*CW +: CW]),
      .sign_bias_o (sign_bias_o[gi])
    );
  end

endmodule
